// File: rtl/dcache_pkg.sv
// dcache_pkg
//   Shared types and geometry for the direct-mapped data cache controller.
//   Contents:
//     DEF_WIDTH / DEF_IDX_W / DEF_CNT_W : default data width, index bits, counter width
//     SETS, TAG_W                       : line count and tag width for the default geometry
//     state_t                           : controller states IDLE / FILL / WRITE
//     addr_split_t, split_addr()        : byte address -> {tag, index}
package dcache_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_IDX_W = 3;
    localparam int DEF_CNT_W = 16;

    localparam int SETS  = 2 ** DEF_IDX_W;
    localparam int TAG_W = DEF_WIDTH - DEF_IDX_W - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [DEF_IDX_W-1:0] index;
    } addr_split_t;

    // Lines are one word wide, so the two byte-offset bits sit below the index.
    function automatic addr_split_t split_addr(input logic [DEF_WIDTH-1:0] a);
        addr_split_t s;
        s.tag   = a[DEF_WIDTH-1:DEF_IDX_W+2];
        s.index = a[DEF_IDX_W+1:2];
        return s;
    endfunction

endpackage

// File: rtl/cache_store_input.sv
// cache_store_input
//   Merges a partial store into the currently cached word. The store data
//   arrives in the low lanes of din and is steered to the byte/half lane
//   selected by the byte offset. Size priority is sw > sh > sb; with no size
//   flag the cached word passes through unchanged.
//   Ports:
//     sw, sh, sb  in   store size flags
//     byte_off    in   addr[1:0] of the store
//     din         in   store data (low lanes)
//     mem_out     in   word currently held in the cache line
//     merged      out  word to write back into the line and to RAM
module cache_store_input (
    input  logic        sw,
    input  logic        sh,
    input  logic        sb,
    input  logic [1:0]  byte_off,
    input  logic [31:0] din,
    input  logic [31:0] mem_out,
    output logic [31:0] merged
);

    always_comb begin
        merged = mem_out;
        if (sw) begin
            merged = din;
        end else if (sh) begin
            // Half-word stores only look at addr[1]; addr[0] is ignored.
            if (byte_off[1]) begin
                merged[31:16] = din[15:0];
            end else begin
                merged[15:0] = din[15:0];
            end
        end else if (sb) begin
            case (byte_off)
                2'd0:    merged[7:0]   = din[7:0];
                2'd1:    merged[15:8]  = din[7:0];
                2'd2:    merged[23:16] = din[7:0];
                default: merged[31:24] = din[7:0];
            endcase
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl
//   Direct-mapped, one-word-per-line, write-through, write-allocate data cache
//   controller between the CPU memory stage and data RAM. Owns the valid/tag/
//   data arrays, answers load hits combinationally, fills lines on any miss
//   and writes every store through to RAM, stalling the CPU while RAM works.
//   The array geometry follows the dcache_pkg defaults.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     req_valid, we         CPU access strobe and store select
//     sw, sh, sb            store size flags
//     addr, din             byte address and store data
//     rd_data, stall        load word on hit, pipeline stall
//     ram_req, ram_we       registered RAM request and write enable
//     ram_addr, ram_wdata   word-aligned RAM address and merged store word
//     ram_rdata, ram_ready  RAM fill data and completion strobe
//     hit_cnt, miss_cnt     saturating lookup hit/miss counters
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             we,
    input  logic             sw,
    input  logic             sh,
    input  logic             sb,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall,
    output logic             ram_req,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata,
    input  logic             ram_ready,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    state_t state;
    state_t next_state;

    logic [SETS-1:0]            valid;
    logic [WIDTH-IDX_W-3:0]     tag_arr  [SETS];
    logic [WIDTH-1:0]           data_arr [SETS];

    addr_split_t req_split;
    addr_split_t fill_split;

    logic             is_store;
    logic             access;
    logic             hit;
    logic [WIDTH-1:0] mem_out;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] word_addr;

    logic start_fill;
    logic start_write;
    logic fill_done;
    logic write_done;
    logic count_hit;
    logic count_miss;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign req_split  = split_addr(addr);
    // The fill target is taken from the registered RAM address so the line
    // written is the one actually requested, whatever the CPU does meanwhile.
    assign fill_split = split_addr(ram_addr);

    // A store with no size flag is not an access at all.
    assign is_store  = we & (sw | sh | sb);
    assign access    = req_valid & (~we | is_store);
    assign hit       = valid[req_split.index] & (tag_arr[req_split.index] == req_split.tag);
    assign mem_out   = data_arr[req_split.index];
    assign word_addr = {addr[WIDTH-1:2], 2'b00};

    cache_store_input u_store_input (
        .sw       (sw),
        .sh       (sh),
        .sb       (sb),
        .byte_off (addr[1:0]),
        .din      (din),
        .mem_out  (mem_out),
        .merged   (merged)
    );

    always_comb begin
        next_state  = state;
        stall       = 1'b0;
        rd_data     = '0;
        start_fill  = 1'b0;
        start_write = 1'b0;
        fill_done   = 1'b0;
        write_done  = 1'b0;
        count_hit   = 1'b0;
        count_miss  = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (!hit) begin
                        // Loads and stores both allocate; a store miss
                        // replays as a store hit once the line is in.
                        stall      = 1'b1;
                        count_miss = 1'b1;
                        start_fill = 1'b1;
                        next_state = FILL;
                    end else if (!we) begin
                        rd_data   = mem_out;
                        count_hit = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        count_hit   = 1'b1;
                        start_write = 1'b1;
                        next_state  = WRITE;
                    end
                end
            end
            FILL: begin
                // Stall stays high in the ready cycle; the request is
                // replayed from IDLE on the following cycle and hits.
                stall = 1'b1;
                if (ram_ready) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            WRITE: begin
                // The array already holds the store, so it retires as soon
                // as RAM accepts the write.
                stall = ~ram_ready;
                if (ram_ready) begin
                    write_done = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state <= next_state;
            if (start_fill) begin
                ram_req  <= 1'b1;
                ram_we   <= 1'b0;
                ram_addr <= word_addr;
            end else if (start_write) begin
                ram_req   <= 1'b1;
                ram_we    <= 1'b1;
                ram_addr  <= word_addr;
                ram_wdata <= merged;
            end else if (fill_done || write_done) begin
                ram_req <= 1'b0;
            end
            if (fill_done) begin
                valid[fill_split.index] <= 1'b1;
            end
            if (count_hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_ONE;
            end
            if (count_miss && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_ONE;
            end
        end
    end

    // Tag/data arrays carry no reset; only the valid bits matter. Writes are
    // suppressed while rst is high so an abandoned fill leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_done) begin
                data_arr[fill_split.index] <= ram_rdata;
                tag_arr[fill_split.index]  <= fill_split.tag;
            end else if (start_write) begin
                data_arr[req_split.index] <= merged;
            end
        end
    end

endmodule
